// File: rtl/ir_nec_transmitter_pkg.sv
// Shared types and NEC segment lengths (in 562.5 us units) for the IR transmit path.
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    REP_SPACE
  } ir_tx_state_t;

  localparam int LEAD_MARK_U  = 16;
  localparam int LEAD_SPACE_U = 8;
  localparam int BIT_MARK_U   = 1;
  localparam int ZERO_SPACE_U = 1;
  localparam int ONE_SPACE_U  = 3;
  localparam int STOP_MARK_U  = 1;
  localparam int REP_SPACE_U  = 4;

  // One NEC unit is 562.5 us, i.e. 9/16000 of a second.
  function automatic int unit_cycles(input int clk_freq_hz);
    return clk_freq_hz * 9 / 16000;
  endfunction

endpackage

// File: rtl/ir_nec_transmitter_if.sv
// Request/status bundle between a frame source (master) and the NEC transmitter (slave).
interface ir_nec_transmitter_if;
  logic        start;
  logic [31:0] tx_data;
  logic        rpt;
  logic        busy;
  logic        done;
  logic        ir_env;
  logic        ir_tx;

  modport master (
    output start, tx_data, rpt,
    input  busy, done, ir_env, ir_tx
  );

  modport slave (
    input  start, tx_data, rpt,
    output busy, done, ir_env, ir_tx
  );
endinterface

// File: rtl/ir_nec_transmitter_carrier_gen.sv
// Square-wave IR carrier; restart forces the high phase to begin on the next cycle.
module ir_carrier_gen #(
  parameter int CARRIER_HALF = 657
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic carrier
);

  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CARRIER_HALF - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      carrier <= 1'b0;
    end else if (restart) begin
      cnt_q   <= RELOAD;
      carrier <= 1'b1;
    end else if (cnt_q == '0) begin
      cnt_q   <= RELOAD;
      carrier <= ~carrier;
    end else begin
      cnt_q   <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/ir_nec_transmitter.sv
// NEC IR frame transmitter: leader, 32 LSB-first pulse-distance bits, stop mark.
// Define IR_TX_REPEAT_EN to honour rpt and send the NEC repeat code.
//
// state      | meaning
// IDLE       | waiting for start; done pulses here for one cycle after a frame
// LEAD_MARK  | 16-unit leader mark
// LEAD_SPACE | 8-unit leader space
// BIT_MARK   | 1-unit mark preceding each data bit
// BIT_SPACE  | 1-unit (0) or 3-unit (1) space for bit idx_q
// STOP_MARK  | 1-unit trailing mark
// REP_SPACE  | 4-unit space of the repeat code (IR_TX_REPEAT_EN only)
module ir_nec_transmitter
  import ir_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int CARRIER_HZ  = 38_000
) (
  input  logic clk,
  input  logic rst,
  ir_nec_transmitter_if.slave bus
);

  localparam int UNIT_CYCLES  = unit_cycles(CLK_FREQ_HZ);
  localparam int CARRIER_HALF = CLK_FREQ_HZ / (2 * CARRIER_HZ);
  localparam int TMR_W        = $clog2(LEAD_MARK_U * UNIT_CYCLES);

  function automatic logic [TMR_W-1:0] seg_load(input int units);
    return TMR_W'(units * UNIT_CYCLES - 1);
  endfunction

  ir_tx_state_t state_q;
  logic [TMR_W-1:0] tmr_q;
  logic [4:0]       idx_q;
  logic [31:0]      data_q;
  logic             busy_q;
  logic             done_q;
  logic             env_q;
  logic             carrier;
  logic             tc;
  logic             mark_entry;

`ifdef IR_TX_REPEAT_EN
  logic rep_q;
`else
  logic unused_rpt;
  assign unused_rpt = bus.rpt;
`endif

  assign tc = (tmr_q == '0);

  // Every transition into a mark restarts the carrier so each mark begins high.
  assign mark_entry = (state_q == IDLE && bus.start) ||
                      (tc && (state_q == LEAD_SPACE || state_q == BIT_SPACE ||
                              state_q == REP_SPACE));

  ir_carrier_gen #(
    .CARRIER_HALF(CARRIER_HALF)
  ) u_carrier (
    .clk     (clk),
    .rst     (rst),
    .restart (mark_entry),
    .carrier (carrier)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      env_q   <= 1'b0;
`ifdef IR_TX_REPEAT_EN
      rep_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && !tc)
        tmr_q <= tmr_q - 1'b1;

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            data_q  <= bus.tx_data;
            idx_q   <= '0;
            tmr_q   <= seg_load(LEAD_MARK_U);
            env_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= LEAD_MARK;
`ifdef IR_TX_REPEAT_EN
            rep_q   <= bus.rpt;
`endif
          end
        end
        LEAD_MARK: begin
          if (tc) begin
            env_q   <= 1'b0;
            state_q <= LEAD_SPACE;
            tmr_q   <= seg_load(LEAD_SPACE_U);
`ifdef IR_TX_REPEAT_EN
            if (rep_q) begin
              state_q <= REP_SPACE;
              tmr_q   <= seg_load(REP_SPACE_U);
            end
`endif
          end
        end
        LEAD_SPACE: begin
          if (tc) begin
            env_q   <= 1'b1;
            state_q <= BIT_MARK;
            tmr_q   <= seg_load(BIT_MARK_U);
          end
        end
        BIT_MARK: begin
          if (tc) begin
            env_q   <= 1'b0;
            state_q <= BIT_SPACE;
            tmr_q   <= data_q[idx_q] ? seg_load(ONE_SPACE_U) : seg_load(ZERO_SPACE_U);
          end
        end
        BIT_SPACE: begin
          if (tc) begin
            env_q <= 1'b1;
            if (idx_q == 5'd31) begin
              state_q <= STOP_MARK;
              tmr_q   <= seg_load(STOP_MARK_U);
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= BIT_MARK;
              tmr_q   <= seg_load(BIT_MARK_U);
            end
          end
        end
        STOP_MARK: begin
          if (tc) begin
            env_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
`ifdef IR_TX_REPEAT_EN
        REP_SPACE: begin
          if (tc) begin
            env_q   <= 1'b1;
            state_q <= STOP_MARK;
            tmr_q   <= seg_load(STOP_MARK_U);
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          env_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.ir_env = env_q;
  // Both operands are flops on clk_sys; the carrier only matters while the envelope is high.
  assign bus.ir_tx  = env_q & carrier;

endmodule

// File: tb/tb_ir_nec_transmitter.sv
// Randomized frame checks of ir_nec_transmitter against a segment-list reference model.
module tb_ir_nec_transmitter;

  // Scaled clock keeps frames short: 1 unit = 36 cycles, carrier half-period = 8 cycles.
  localparam int CLK_HZ = 64_000;
  localparam int CAR_HZ = 4_000;
  localparam int U      = CLK_HZ * 9 / 16000;
  localparam int HALF   = CLK_HZ / (2 * CAR_HZ);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  bit exp_env[$];
  bit exp_tx[$];
  int exp_len;

  ir_nec_transmitter_if bus ();

  ir_nec_transmitter #(
    .CLK_FREQ_HZ(CLK_HZ),
    .CARRIER_HZ (CAR_HZ)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit rep_active(input bit r);
`ifdef IR_TX_REPEAT_EN
    return r;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: list of alternating mark/space lengths in units, expanded per cycle.
  task automatic build(input logic [31:0] d, input bit r);
    int segs[$];
    exp_env.delete();
    exp_tx.delete();
    segs.push_back(16);
    if (rep_active(r)) begin
      segs.push_back(4);
    end else begin
      segs.push_back(8);
      for (int i = 0; i < 32; i++) begin
        segs.push_back(1);
        segs.push_back(d[i] ? 3 : 1);
      end
    end
    segs.push_back(1);
    foreach (segs[k]) begin
      for (int c = 0; c < segs[k] * U; c++) begin
        exp_env.push_back(k % 2 == 0);
        exp_tx.push_back((k % 2 == 0) && ((c / HALF) % 2 == 0));
      end
    end
    exp_len = exp_env.size();
  endtask

  function automatic int bit10_space_t(input logic [31:0] d);
    int units = 24;
    for (int i = 0; i < 10; i++) units += 1 + (d[i] ? 3 : 1);
    return (units + 1) * U + 5;
  endfunction

  task automatic issue(input logic [31:0] d, input bit r);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.tx_data = d;
    bus.rpt     = r;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.rpt   = 1'b0;
  endtask

  // t = 0 is the sample just after the edge that accepted start.
  task automatic watch(input logic [31:0] d, input bit r, input int mid_t, input int rst_t,
                       input bit chain, input logic [31:0] chain_d);
    int env_err, tx_err, busy_err, done_err, done_t, run, last_t;
    int runs[$];
    logic prev;
    logic [31:0] word;
    bit aborted;
    env_err = 0; tx_err = 0; busy_err = 0; done_err = 0;
    done_t = -1; run = 0; prev = 1'b0; word = '0; aborted = 1'b0;
    build(d, r);
    last_t = chain ? exp_len : exp_len + 2 * U;
    for (int t = 0; t <= last_t; t++) begin
      if (bus.ir_env !== ((t < exp_len) ? exp_env[t] : 1'b0)) env_err++;
      if (bus.ir_tx  !== ((t < exp_len) ? exp_tx[t]  : 1'b0)) tx_err++;
      if (bus.busy   !== (t < exp_len)) busy_err++;
      if (bus.done   !== (t == exp_len)) done_err++;
      if (bus.done === 1'b1 && done_t < 0) done_t = t;
      if (t > 0 && bus.ir_env !== prev) begin
        runs.push_back(run);
        run = 0;
      end
      prev = bus.ir_env;
      run++;
      if (t == rst_t) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_async_busy", bus.busy, 0);
        chk("rst_async_done", bus.done, 0);
        chk("rst_async_env", bus.ir_env, 0);
        chk("rst_async_tx", bus.ir_tx, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2 * U) @(posedge clk);
        #1;
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_env", bus.ir_env, 0);
        aborted = 1'b1;
        break;
      end
      if (t == mid_t) begin
        bus.start   = 1'b1;
        bus.tx_data = ~d;
      end else if (t == mid_t + 1) begin
        bus.start = 1'b0;
      end
      if (chain && t == exp_len) begin
        bus.start   = 1'b1;
        bus.tx_data = chain_d;
      end
      @(posedge clk);
      #1;
    end
    if (chain) bus.start = 1'b0;
    chk("env_err_cycles", env_err, 0);
    chk("tx_err_cycles", tx_err, 0);
    chk("busy_err_cycles", busy_err, 0);
    chk("done_err_cycles", done_err, 0);
    if (!aborted) begin
      chk("done_cycle", done_t, exp_len);
      if (rep_active(r)) begin
        chk("rep_runs", runs.size(), 3);
      end else begin
        for (int i = 0; i < 32; i++)
          if (runs.size() > 3 + 2 * i) word[i] = (runs[3 + 2 * i] > 2 * U);
        chk("decoded_word", word, d);
      end
    end
  endtask

  initial begin
    logic [31:0] d, d2;
    bus.start   = 1'b0;
    bus.tx_data = '0;
    bus.rpt     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_env", bus.ir_env, 0);
    chk("reset_tx", bus.ir_tx, 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);

    issue(32'h0000_0000, 1'b0);
    watch(32'h0000_0000, 1'b0, -1, -1, 1'b0, '0);
    chk("zero_frame_len", exp_len, 89 * U);

    issue(32'hFF00_BF40, 1'b0);
    watch(32'hFF00_BF40, 1'b0, -1, -1, 1'b0, '0);

    d = $urandom;
    issue(d, 1'b0);
    watch(d, 1'b0, 1000, -1, 1'b0, '0);

    d  = $urandom;
    d2 = $urandom;
    issue(d, 1'b0);
    watch(d, 1'b0, -1, -1, 1'b1, d2);
    watch(d2, 1'b0, -1, -1, 1'b0, '0);

    d = $urandom;
    issue(d, 1'b0);
    watch(d, 1'b0, -1, bit10_space_t(d), 1'b0, '0);
    d = $urandom;
    issue(d, 1'b0);
    watch(d, 1'b0, -1, -1, 1'b0, '0);

    issue(32'hFFFF_FFFF, 1'b0);
    watch(32'hFFFF_FFFF, 1'b0, -1, -1, 1'b0, '0);
    chk("ones_frame_len", exp_len, 153 * U);

    d = $urandom;
    issue(d, 1'b1);
    watch(d, 1'b1, -1, -1, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
